free_list: RTL and testbench

//  Physical-register free list for the rename stage; sits directly upstream of the register alias table.

---
 rtl/ooo_pkg.sv | 14 +
 rtl/free_list_if.sv | 31 +++
 rtl/free_list_ptr.sv | 37 +++
 rtl/free_list.sv | 110 +++++++++++
 tb/tb_free_list.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/ooo_pkg.sv
// Shared out-of-order core types and sizes (free list, alias table, ROB).
package ooo_pkg;
  localparam int PHYS_W   = 6;
  localparam int NUM_PHYS = 64;
  localparam int NUM_ARCH = 32;
  localparam int FL_DEPTH = NUM_PHYS - NUM_ARCH;
  localparam int FL_IDX_W = $clog2(FL_DEPTH);
  localparam int FL_PTR_W = FL_IDX_W + 1;   // extra wrap bit separates full from empty
  localparam int FL_CNT_W = FL_PTR_W + 1;

  typedef logic [PHYS_W-1:0]   phys_tag_t;
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;
  typedef logic [FL_CNT_W-1:0] fl_cnt_t;
endpackage

// File: rtl/free_list_if.sv
// Rename-side interface of the physical register free list.
//
// Handshake: alloc_req is the consumer's request and alloc_ok is the
// producer's "valid tag" flag. A tag transfers on a rising clock edge when
// alloc_req && alloc_ok && !stall && !recover are all high; alloc_tag is
// only meaningful while alloc_ok is high. free_req and commit_alloc are
// unconditional one-cycle pulses with no back-pressure.
interface free_list_if
  import ooo_pkg::*;
();
  logic      stall;
  logic      alloc_req;
  phys_tag_t alloc_tag;
  logic      alloc_ok;
  logic      free_req;
  phys_tag_t free_tag;
  logic      commit_alloc;
  logic      recover;
  fl_cnt_t   free_count;
  logic      overflow;

  modport master (
    output stall, alloc_req, free_req, free_tag, commit_alloc, recover,
    input  alloc_tag, alloc_ok, free_count, overflow
  );

  modport slave (
    input  stall, alloc_req, free_req, free_tag, commit_alloc, recover,
    output alloc_tag, alloc_ok, free_count, overflow
  );
endinterface

// File: rtl/free_list_ptr.sv
// Wrapping free-list pointer: load has priority over increment.
module free_list_ptr
  import ooo_pkg::*;
#(
  parameter fl_ptr_t RESET_VAL = '0
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    inc_i,
  input  logic    load_i,
  input  fl_ptr_t load_val_i,
  output fl_ptr_t ptr_o
);
  fl_ptr_t ptr_q;
  fl_ptr_t ptr_d;

  // Next pointer: restore on load, otherwise step by one when asked.
  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = load_val_i;
    end else if (inc_i) begin
      ptr_d = ptr_q + fl_ptr_t'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= RESET_VAL;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/free_list.sv
// Physical register free list with speculative and retirement heads.
// Optional build macro: FREE_LIST_BYPASS_EN forwards a same-cycle released
// tag straight to the allocator when the list is empty.
module free_list
  import ooo_pkg::*;
(
  input logic        clk,
  input logic        reset,
  free_list_if.slave fl
);
  phys_tag_t entry_q [FL_DEPTH];
  fl_ptr_t   spec_q;
  fl_ptr_t   retire_q;
  fl_ptr_t   tail_q;
  fl_ptr_t   occupancy;
  fl_ptr_t   spec_load_val;
  logic      overflow_q;
  logic      list_empty;
  logic      list_full;
  logic      free_valid;
  logic      free_accept;
  logic      bypass_hit;
  logic      alloc_fire;
  logic      spec_inc;
  logic      tail_inc;

  // Empty is judged against the speculative head, full against the
  // retirement head: uncommitted allocations still own their slots.
  assign list_empty  = (tail_q == spec_q);
  assign list_full   = ((tail_q - retire_q) == fl_ptr_t'(FL_DEPTH));
  assign free_valid  = fl.free_req && (fl.free_tag != '0);
  assign free_accept = free_valid && !list_full;

`ifdef FREE_LIST_BYPASS_EN
  assign bypass_hit = list_empty && free_accept;
`else
  assign bypass_hit = 1'b0;
`endif

  assign fl.alloc_ok  = !list_empty || bypass_hit;
  assign fl.alloc_tag = bypass_hit ? fl.free_tag : entry_q[spec_q[FL_IDX_W-1:0]];

  assign alloc_fire = fl.alloc_req && fl.alloc_ok && !fl.stall && !fl.recover;
  // A forwarded tag never enters the array, so neither pointer moves for it.
  assign spec_inc   = alloc_fire && !bypass_hit;
  assign tail_inc   = free_accept && !(bypass_hit && alloc_fire);

  // A flush rewinds to the committed head, counting a same-cycle commit.
  assign spec_load_val = retire_q + fl_ptr_t'(fl.commit_alloc);

  free_list_ptr #(.RESET_VAL('0)) u_spec_ptr (
    .clk_i      (clk),
    .rst_ni     (reset),
    .inc_i      (spec_inc),
    .load_i     (fl.recover),
    .load_val_i (spec_load_val),
    .ptr_o      (spec_q)
  );

  free_list_ptr #(.RESET_VAL('0)) u_retire_ptr (
    .clk_i      (clk),
    .rst_ni     (reset),
    .inc_i      (fl.commit_alloc),
    .load_i     (1'b0),
    .load_val_i ('0),
    .ptr_o      (retire_q)
  );

  free_list_ptr #(.RESET_VAL(fl_ptr_t'(FL_DEPTH))) u_tail_ptr (
    .clk_i      (clk),
    .rst_ni     (reset),
    .inc_i      (tail_inc),
    .load_i     (1'b0),
    .load_val_i ('0),
    .ptr_o      (tail_q)
  );

  // Tag storage: preloaded with the unmapped physical registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        entry_q[i] <= phys_tag_t'(NUM_ARCH + i);
      end
    end else if (tail_inc) begin
      entry_q[tail_q[FL_IDX_W-1:0]] <= fl.free_tag;
    end
  end

  // Sticky flag for a release that found no room.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (free_valid && list_full) begin
      overflow_q <= 1'b1;
    end
  end

  assign occupancy     = tail_q - spec_q;
  assign fl.free_count = {1'b0, occupancy};
  assign fl.overflow   = overflow_q;

`ifndef SYNTHESIS
  // Committing an allocation that was never handed out corrupts the heads.
  a_commit_outstanding: assert property (@(posedge clk) disable iff (!reset)
    fl.commit_alloc |-> (spec_q != retire_q));
  // Heads stay ordered: retire <= spec <= tail (modular).
  a_head_order: assert property (@(posedge clk) disable iff (!reset)
    (fl_ptr_t'(spec_q - retire_q) <= fl_ptr_t'(tail_q - retire_q)));
`endif
endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed scenarios then random traffic
// against a queue-based model of the free and in-flight tag sets.
module tb_free_list;
  logic clk;
  logic reset;

  free_list_if fl();

  free_list dut (
    .clk   (clk),
    .reset (reset),
    .fl    (fl)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: exp_q holds allocatable tags in order, inflight_q holds
  // allocated-but-uncommitted tags oldest first.
  logic [5:0] exp_q[$];
  logic [5:0] inflight_q[$];
  logic       ovf_m;

  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    fl.stall        = 1'b0;
    fl.alloc_req    = 1'b0;
    fl.free_req     = 1'b0;
    fl.free_tag     = '0;
    fl.commit_alloc = 1'b0;
    fl.recover      = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b0;
    exp_q.delete();
    inflight_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(6'(32 + i));
    ovf_m = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One cycle: drive inputs, check outputs against the model, advance both.
  task automatic step(input logic st, input logic areq, input logic freq,
                      input logic [5:0] ftag, input logic cmt, input logic rec);
    logic       fvalid, faccept, bypass, exp_ok, fire;
    logic [5:0] exp_tag;
    @(negedge clk);
    fl.stall        = st;
    fl.alloc_req    = areq;
    fl.free_req     = freq;
    fl.free_tag     = ftag;
    fl.commit_alloc = cmt;
    fl.recover      = rec;
    #1;
    fvalid  = freq && (ftag != 6'd0);
    faccept = fvalid && ((exp_q.size() + inflight_q.size()) < 32);
    bypass  = 1'b0;
`ifdef FREE_LIST_BYPASS_EN
    bypass  = faccept && (exp_q.size() == 0);
`endif
    exp_ok  = (exp_q.size() != 0) || bypass;
    exp_tag = bypass ? ftag : ((exp_q.size() != 0) ? exp_q[0] : 6'd0);
    check("alloc_ok", fl.alloc_ok, exp_ok);
    if (exp_ok) check("alloc_tag", fl.alloc_tag, exp_tag);
    check("free_count", fl.free_count, exp_q.size());
    check("overflow", fl.overflow, ovf_m);
    fire = areq && exp_ok && !st && !rec;
    if (fire && !bypass) inflight_q.push_back(exp_q.pop_front());
    if (cmt) void'(inflight_q.pop_front());
    if (rec) begin
      while (inflight_q.size() > 0) exp_q.push_front(inflight_q.pop_back());
    end
    if (faccept && !(bypass && fire)) exp_q.push_back(ftag);
    if (fvalid && !faccept) ovf_m = 1'b1;
    @(posedge clk);
  endtask

  // Idle cycle used for constant spot checks; the model does not move.
  task automatic probe();
    @(negedge clk);
    drive_idle();
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    do_reset();

    // Reset values
    probe();
    check("rst_alloc_tag", fl.alloc_tag, 32);
    check("rst_free_count", fl.free_count, 32);
    check("rst_alloc_ok", fl.alloc_ok, 1);
    check("rst_overflow", fl.overflow, 0);

    // Drain the whole list: tags 32..63 in order
    for (int i = 0; i < 32; i++) step(0, 1, 0, 0, 0, 0);
    probe();
    check("drain_alloc_ok", fl.alloc_ok, 0);
    check("drain_free_count", fl.free_count, 0);

    // 5 allocs, 2 commits, flush
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    probe();
    check("recover_tag", fl.alloc_tag, 34);
    check("recover_count", fl.free_count, 30);

    // Release into an empty list
    do_reset();
    for (int i = 0; i < 32; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 6'd40, 0, 0);
    probe();
    check("empty_free_tag", fl.alloc_tag, 40);
    check("empty_free_ok", fl.alloc_ok, 1);

    // Stall gates allocation only
    step(0, 0, 0, 0, 1, 0);
    step(1, 1, 1, 6'd7, 0, 0);
    probe();
    check("stall_count", fl.free_count, 2);
    check("stall_tag", fl.alloc_tag, 40);

    // Alloc and free together on an empty list (bypass-dependent)
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 6'd41, 0, 0);
    step(0, 1, 0, 0, 0, 0);

    // Release while full
    do_reset();
    step(0, 0, 1, 6'd9, 0, 0);
    probe();
    check("full_overflow", fl.overflow, 1);
    check("full_count", fl.free_count, 32);

    // Tag 0 is never freed
    do_reset();
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 6'd0, 0, 0);
    probe();
    check("zero_count", fl.free_count, 31);
    check("zero_overflow", fl.overflow, 0);
    check("zero_tag", fl.alloc_tag, 33);

    // Random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic       st, areq, freq, cmt, rec;
      logic [5:0] ftag;
      st   = ($urandom_range(0, 99) < 15);
      areq = ($urandom_range(0, 99) < 60);
      freq = ($urandom_range(0, 99) < 45);
      ftag = ($urandom_range(0, 19) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      cmt  = (inflight_q.size() > 0) && ($urandom_range(0, 99) < 50);
      rec  = ($urandom_range(0, 99) < 3);
      step(st, areq, freq, ftag, cmt, rec);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
